if_stage: RTL and testbench

- Instruction-fetch stage for the pipelined RV32I core; first pipeline stage, directly upstream of decode.
- Owns the PC register and drives the combinational instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, later-stage branch/jump redirects with flush, and instruction-address-misaligned faults.

---
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control inputs, instruction memory port,
// and the IF/ID register outputs.
interface if_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_misaligned;
  logic [31:0] fetch_count;

  modport master (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4,
    input  if_id_instr, if_id_misaligned, fetch_count
  );

  modport slave (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4,
    output if_id_instr, if_id_misaligned, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID register,
// redirect/flush, stall hold and misaligned-fetch fault.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic      clk,
  input logic      reset,
  if_stage_if.slave bus
);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        misaligned;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    valid:      1'b0,
    pc:         32'h0,
    pc_plus4:   32'h0,
    instr:      NOP_INSTR,
    misaligned: 1'b0
  };

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] pc_inc;
  if_id_t      ifid, ifid_nxt;

  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      cnt   <= 32'h0;
      ifid  <= BUBBLE;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      ifid  <= ifid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    ifid_nxt  = ifid;
    if (bus.redirect) begin
      state_nxt = RUN;
      pc_nxt    = bus.redirect_pc;
      ifid_nxt  = BUBBLE;
    end else if (!bus.stall) begin
      unique case (state)
        RUN: begin
          cnt_nxt           = cnt + 32'd1;
          ifid_nxt.valid    = 1'b1;
          ifid_nxt.pc       = pc;
          ifid_nxt.pc_plus4 = pc_inc;
          if (pc[1:0] == 2'b00) begin
            ifid_nxt.instr      = bus.imem_instr;
            ifid_nxt.misaligned = 1'b0;
            pc_nxt              = pc_inc;
          end else begin
            // Faulting entry carries a NOP so decode sees no side effects
            ifid_nxt.instr      = NOP_INSTR;
            ifid_nxt.misaligned = 1'b1;
            state_nxt           = FAULT;
          end
        end
        FAULT: ifid_nxt = BUBBLE;
        default: ifid_nxt = BUBBLE;
      endcase
    end
  end

  assign bus.imem_addr        = {pc[31:2], 2'b00};
  assign bus.if_id_valid      = ifid.valid;
  assign bus.if_id_pc         = ifid.pc;
  assign bus.if_id_pc_plus4   = ifid.pc_plus4;
  assign bus.if_id_instr      = ifid.instr;
  assign bus.if_id_misaligned = ifid.misaligned;
  assign bus.fetch_count      = cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free run, stall, redirect/flush,
// misaligned fault, address wrap and reset out of FAULT.
module tb_if_stage;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h00500093;
      32'h4:   mem = 32'h00a00113;
      32'h8:   mem = 32'h002081b3;
      default: mem = a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign bus.imem_instr = mem(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic v,
                           input logic [31:0] p, input logic [31:0] p4,
                           input logic [31:0] ins, input logic mis);
    chk({tag, "_valid"}, {31'h0, bus.if_id_valid}, {31'h0, v});
    chk({tag, "_pc"}, bus.if_id_pc, p);
    chk({tag, "_pc4"}, bus.if_id_pc_plus4, p4);
    chk({tag, "_instr"}, bus.if_id_instr, ins);
    chk({tag, "_mis"}, {31'h0, bus.if_id_misaligned}, {31'h0, mis});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    step();
    step();
    reset = 1'b0;
    chk_entry("rst", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    chk("rst_cnt", bus.fetch_count, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);

    step();
    chk_entry("f0", 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b0);
    step();
    chk_entry("f1", 1'b1, 32'h4, 32'h8, 32'h00a00113, 1'b0);
    step();
    chk_entry("f2", 1'b1, 32'h8, 32'hC, 32'h002081b3, 1'b0);
    chk("f2_cnt", bus.fetch_count, 32'd3);
    chk("f2_addr", bus.imem_addr, 32'hC);

    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_entry("stl", 1'b1, 32'h8, 32'hC, 32'h002081b3, 1'b0);
      chk("stl_cnt", bus.fetch_count, 32'd3);
      chk("stl_addr", bus.imem_addr, 32'hC);
    end
    bus.stall = 1'b0;
    step();
    chk_entry("rel", 1'b1, 32'hC, 32'h10, 32'hDEAD_000C, 1'b0);
    chk("rel_cnt", bus.fetch_count, 32'd4);

    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    chk_entry("flush", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    chk("flush_addr", bus.imem_addr, 32'h40);
    chk("flush_cnt", bus.fetch_count, 32'd4);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    chk_entry("tgt", 1'b1, 32'h40, 32'h44, 32'hDEAD_0040, 1'b0);
    chk("tgt_cnt", bus.fetch_count, 32'd5);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h46;
    step();
    chk("mis_addr", bus.imem_addr, 32'h44);
    bus.redirect = 1'b0;
    step();
    chk_entry("mis", 1'b1, 32'h46, 32'h4A, 32'h13, 1'b1);
    chk("mis_cnt", bus.fetch_count, 32'd6);
    step();
    chk_entry("fb0", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    chk("fb0_addr", bus.imem_addr, 32'h44);
    chk("fb0_cnt", bus.fetch_count, 32'd6);
    step();
    chk_entry("fb1", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    chk("fb1_addr", bus.imem_addr, 32'h44);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    chk("r80_addr", bus.imem_addr, 32'h80);
    bus.redirect = 1'b0;
    step();
    chk_entry("r80", 1'b1, 32'h80, 32'h84, 32'hDEAD_0080, 1'b0);
    chk("r80_cnt", bus.fetch_count, 32'd7);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    step();
    chk_entry("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h2152_FFFC, 1'b0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    step();
    chk_entry("wrap1", 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b0);
    chk("wrap1_cnt", bus.fetch_count, 32'd9);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h6;
    step();
    bus.redirect = 1'b0;
    step();
    chk("m2_mis", {31'h0, bus.if_id_misaligned}, 32'h1);
    chk("m2_cnt", bus.fetch_count, 32'd10);
    step();
    bus.stall = 1'b1;
    reset = 1'b1;
    step();
    chk_entry("rstf", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    chk("rstf_cnt", bus.fetch_count, 32'd0);
    chk("rstf_addr", bus.imem_addr, 32'h0);
    bus.stall = 1'b0;
    reset = 1'b0;
    step();
    chk_entry("rstf_run", 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b0);
    chk("rstf_run_cnt", bus.fetch_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
